// File: rtl/qs_fifo.sv
// Single-clock show-ahead FIFO with push/pop handshakes and count-based flags.
// Optional sticky overflow/underflow outputs are compiled in with QS_FIFO_ERR_FLAGS_EN.
module qs_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
`ifdef QS_FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow_o,
    output logic              underflow_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_acc_s;
    logic              pop_acc_s;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Handshake acceptance and flag decode from the registered count.
    always_comb begin
        full_o     = (count_r == CNT_W'(DEPTH));
        empty_o    = (count_r == {CNT_W{1'b0}});
        push_acc_s = push_i && !full_o;
        pop_acc_s  = pop_i && !empty_o;
        pop_data_o = mem_r[rd_ptr_r];
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_r] <= push_data_i;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_acc_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef QS_FIFO_ERR_FLAGS_EN
    // Sticky error flags record any rejected request until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_i && full_o) begin
                overflow_o <= 1'b1;
            end
            if (pop_i && empty_o) begin
                underflow_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qs_fifo.sv
// Randomized self-checking bench for qs_fifo against a queue-based reference model.
// Define QS_FIFO_ERR_FLAGS_EN to also check the sticky error flags.
module tb_qs_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              reset;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              full;
    logic              empty;
`ifdef QS_FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    logic [DATA_W-1:0] model_q [$];
    logic              ovf_m;
    logic              unf_m;
    int                vec_cnt;
    int                err_cnt;

    qs_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (pop_data),
        .full_o      (full),
        .empty_o     (empty)
`ifdef QS_FIFO_ERR_FLAGS_EN
        ,
        .overflow_o  (overflow),
        .underflow_o (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("full", 32'(full), 32'(model_q.size() == DEPTH));
        if (model_q.size() > 0) begin
            check("head", 32'(pop_data), 32'(model_q[0]));
        end
`ifdef QS_FIFO_ERR_FLAGS_EN
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("underflow", 32'(underflow), 32'(unf_m));
`endif
    endtask

    // One clock edge with the given request; the model decides acceptance from pre-edge occupancy.
    task automatic step(input logic p, input logic [DATA_W-1:0] d, input logic o);
        bit push_ok;
        bit pop_ok;
        @(negedge clk);
        push      = p;
        push_data = d;
        pop       = o;
        push_ok   = p && (model_q.size() < DEPTH);
        pop_ok    = o && (model_q.size() > 0);
        if (p && model_q.size() == DEPTH) ovf_m = 1'b1;
        if (o && model_q.size() == 0) unf_m = 1'b1;
        @(posedge clk);
        if (pop_ok) void'(model_q.pop_front());
        if (push_ok) model_q.push_back(d);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        repeat (cycles) @(posedge clk);
        model_q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        #1;
        compare_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = 8'h00;
        ovf_m     = 1'b0;
        unf_m     = 1'b0;

        // 1: reset then idle
        do_reset(2);
        step(1'b0, 8'h00, 1'b0);

        // 2: fill with random bytes
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0);
        check("full_after_fill", 32'(full), 32'd1);

        // 3: drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
        check("empty_after_drain", 32'(empty), 32'd1);

        // 4: full boundary
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        check("full_after_pushpop", 32'(full), 32'd0);
`ifdef QS_FIFO_ERR_FLAGS_EN
        check("overflow_set", 32'(overflow), 32'd1);
`endif
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // 5: push+pop on empty, then random traffic through wraps
        step(1'b1, 8'h5C, 1'b1);
        check("head_5c", 32'(pop_data), 32'h5C);
        check("empty_5c", 32'(empty), 32'd0);
`ifdef QS_FIFO_ERR_FLAGS_EN
        check("underflow_set", 32'(underflow), 32'd1);
`endif
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50));
        end

        // 6: reset with 5 entries held
        while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        do_reset(1);
        check("empty_after_rst", 32'(empty), 32'd1);
        check("full_after_rst", 32'(full), 32'd0);
        step(1'b1, 8'h3E, 1'b0);
        check("first_after_rst", 32'(pop_data), 32'h3E);
        step(1'b1, 8'h71, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
